// File: rtl/scan_index_gen.sv
// scan_index_gen
//   Produces the 3-bit select index {a2,a1,a0} feeding a 3-to-8 decoder that
//   multiplexes digits/LEDs. The index advances on a prescaled free-running
//   scan (up or down) or on single-step pulses, and can be loaded directly.
//
// Parameters
//   DIV    clk cycles per index advance while scanning (2..65535)
//   LAST   highest index in the scan (1..7); index runs 0..LAST
//   BLANK  dead-time cycles before each index change (1..DIV-2), blanking build only
//
// Optional feature (macro SCAN_BLANK_EN)
//   Defined: RUN -> BLANK -> RUN FSM. Each advance first drops valid for BLANK
//   cycles, then the index changes and valid returns high on the same edge.
//   Undefined: no FSM, index changes on the edge after the advance event.
//
// Ports
//   clk       in   rising-edge clock
//   reset_p   in   asynchronous reset, active-high
//   en_scan   in   1 = free-running scan, 0 = hold (step allowed)
//   dir       in   0 = count up, 1 = count down
//   step      in   1-cycle pulse, advance one index (only while en_scan = 0)
//   load      in   synchronous load of load_val (wins over any advance)
//   load_val  in   index to load, clamped to LAST
//   a2,a1,a0  out  registered select index, a2 = MSB
//   valid     out  index qualifier
//   wrap      out  1-cycle pulse when the index wraps (LAST->0 up, 0->LAST down)
//
// Output qualification: there is no backpressure. The decoder may use the index
// in every cycle where valid = 1; valid = 0 only marks blanking dead-time.
module scan_index_gen #(
  parameter int DIV   = 1000,
  parameter int LAST  = 7,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       en_scan,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic       a2,
  output logic       a1,
  output logic       a0,
  output logic       valid,
  output logic       wrap
);

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);
  localparam logic [2:0]  LAST3  = 3'(LAST);

  // Elaboration-time guard against out-of-range parameters.
  if (DIV < 2 || DIV > 65535 || LAST < 1 || LAST > 7 || BLANK < 1 || BLANK > DIV - 2)
  begin : g_param_check
    $error("scan_index_gen: parameter out of range");
  end

  logic [2:0]  idx;
  logic [15:0] pcnt;
  logic        tick;
  logic        adv_evt;
  logic [2:0]  load_clamped;

  function automatic logic [2:0] next_idx(input logic [2:0] cur, input logic down);
    if (!down) next_idx = (cur == LAST3) ? 3'd0 : cur + 3'd1;
    else       next_idx = (cur == 3'd0) ? LAST3 : cur - 3'd1;
  endfunction

  function automatic logic wraps(input logic [2:0] cur, input logic down);
    wraps = down ? (cur == 3'd0) : (cur == LAST3);
  endfunction

  assign tick         = en_scan && (pcnt == DIV_M1);
  assign adv_evt      = en_scan ? tick : step;
  assign load_clamped = (load_val > LAST3) ? LAST3 : load_val;

  // Prescaler: held at 0 while scanning is disabled, so re-enabling always
  // gives a full DIV-cycle period before the first advance.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)                     pcnt <= '0;
    else if (load || !en_scan || tick) pcnt <= '0;
    else                             pcnt <= pcnt + 16'd1;
  end

`ifdef SCAN_BLANK_EN
  localparam logic [15:0] BLANK_M1 = 16'(BLANK - 1);

  typedef enum logic {S_RUN = 1'b0, S_BLANK = 1'b1} state_t;

  state_t      state, state_nx;
  logic [15:0] bcnt;
  logic        pend_dir;
  logic        blank_done;

  // State register
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) state <= S_RUN;
    else         state <= state_nx;
  end

  // Next-state logic: load aborts a blank; advances are only accepted in RUN.
  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (!load && adv_evt) state_nx = S_BLANK;
      S_BLANK: if (load || bcnt == BLANK_M1) state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  // Output logic: valid is the decoded state register bit, so it is glitch-free.
  always_comb begin
    valid      = (state == S_RUN);
    blank_done = (state == S_BLANK) && !load && (bcnt == BLANK_M1);
  end

  // Blank counter and direction captured at the advance event.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      bcnt     <= '0;
      pend_dir <= 1'b0;
    end else begin
      bcnt <= (state == S_RUN) ? 16'd0 : bcnt + 16'd1;
      if (state == S_RUN && adv_evt) pend_dir <= dir;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      idx  <= 3'd0;
      wrap <= 1'b0;
    end else if (load) begin
      idx  <= load_clamped;
      wrap <= 1'b0;
    end else if (blank_done) begin
      idx  <= next_idx(idx, pend_dir);
      wrap <= wraps(idx, pend_dir);
    end else begin
      wrap <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      idx  <= 3'd0;
      wrap <= 1'b0;
    end else if (load) begin
      idx  <= load_clamped;
      wrap <= 1'b0;
    end else if (adv_evt) begin
      idx  <= next_idx(idx, dir);
      wrap <= wraps(idx, dir);
    end else begin
      wrap <= 1'b0;
    end
  end

  // Without blanking the index is always usable.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) valid <= 1'b1;
    else         valid <= 1'b1;
  end
`endif

  assign {a2, a1, a0} = idx;

endmodule
